// File: rtl/top.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : top                                                              |
// | Phased-array driver: FT245 byte reader, phase packet parser, and         |
// | per-channel phase-shifted 50 % square-wave generators.                   |
// | Rev    : 1.0                                                              |
// +--------------------------------------------------------------------------+
module top #(
    parameter int NUM_CHANNELS = 128,
    parameter int PERIOD       = 1250,
    parameter int RD_LOW       = 4,
    parameter int RD_GAP       = 3
) (
    input  logic                    sys_clk,
    input  logic                    ext_rst,
    input  logic                    sync_in,
    output logic                    sync_out,
    output logic [NUM_CHANNELS-1:0] trans,
    inout  wire  [7:0]              ft_data,
    input  logic                    ft_txen,
    input  logic                    ft_rxfn,
    output logic                    ft_rdn,
    output logic                    ft_wrn,
    input  logic                    ft_clk,
    output logic                    ft_oen,
    output logic                    ft_siwu
);

    localparam int c_CNT_W  = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam int c_CMP_W  = (c_CNT_W > 11) ? c_CNT_W + 1 : 12;
    localparam int c_RD_MAX = (RD_LOW > RD_GAP) ? RD_LOW : RD_GAP;
    localparam int c_RD_W   = $clog2(c_RD_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX     = c_CNT_W'(PERIOD - 1);
    localparam logic [c_CNT_W:0]   c_PERIOD_X    = (c_CNT_W + 1)'(PERIOD);
    localparam logic [c_CNT_W:0]   c_HALF        = (c_CNT_W + 1)'(PERIOD / 2);
    localparam logic [c_CMP_W-1:0] c_PERIOD_CMP  = c_CMP_W'(PERIOD);
    localparam logic [7:0]         c_NCH         = 8'(NUM_CHANNELS);
    localparam logic [c_RD_W-1:0]  c_RD_LOW_LAST = c_RD_W'(RD_LOW - 1);
    localparam logic [c_RD_W-1:0]  c_RD_GAP_LAST = c_RD_W'(RD_GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_GAP  = 2'd2
    } rd_state_t;

    assign ft_data = 8'hzz;
    assign ft_wrn  = 1'b1;
    assign ft_oen  = 1'b1;
    assign ft_siwu = 1'b1;

    logic w_unused;
    logic [6:0] r_hi;
    assign w_unused = ^{ft_txen, ft_clk, r_hi[6:4]};

    // rxfn synchronizer starts at its inactive level so no read launches out of reset
    logic r_rxfn_meta, r_rxfn_sync;
    logic r_sin_meta, r_sin_sync, r_sin_prev;
    logic w_sync_edge;

    always_ff @(posedge sys_clk or posedge ext_rst) begin
        if (ext_rst) begin
            r_rxfn_meta <= 1'b1;
            r_rxfn_sync <= 1'b1;
            r_sin_meta  <= 1'b0;
            r_sin_sync  <= 1'b0;
            r_sin_prev  <= 1'b0;
        end else begin
            r_rxfn_meta <= ft_rxfn;
            r_rxfn_sync <= r_rxfn_meta;
            r_sin_meta  <= sync_in;
            r_sin_sync  <= r_sin_meta;
            r_sin_prev  <= r_sin_sync;
        end
    end

    assign w_sync_edge = r_sin_sync & ~r_sin_prev;

    rd_state_t         r_state;
    logic [c_RD_W-1:0] r_rd_cnt;
    logic              r_rdn;
    logic [7:0]        rxfifo_data;
    logic              r_byte_valid;

    always_ff @(posedge sys_clk or posedge ext_rst) begin
        if (ext_rst) begin
            r_state      <= S_IDLE;
            r_rd_cnt     <= '0;
            r_rdn        <= 1'b1;
            rxfifo_data  <= 8'h00;
            r_byte_valid <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rxfn_sync) begin
                        r_state  <= S_READ;
                        r_rdn    <= 1'b0;
                        r_rd_cnt <= '0;
                    end
                end
                S_READ: begin
                    if (r_rd_cnt == c_RD_LOW_LAST) begin
                        rxfifo_data  <= ft_data;
                        r_byte_valid <= 1'b1;
                        r_rdn        <= 1'b1;
                        r_state      <= S_GAP;
                        r_rd_cnt     <= '0;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // Chain straight into the next read so the high time stays RD_GAP cycles
                    if (r_rd_cnt == c_RD_GAP_LAST) begin
                        r_rd_cnt <= '0;
                        if (!r_rxfn_sync) begin
                            r_state <= S_READ;
                            r_rdn   <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdn   <= 1'b1;
                end
            endcase
        end
    end

    assign ft_rdn = r_rdn;

    logic [1:0]         r_expect;
    logic [6:0]         r_chan;
    logic               r_wr_en;
    logic [6:0]         r_wr_chan;
    logic [c_CNT_W-1:0] r_wr_phase;
    logic [10:0]        w_pkt_phase;
    logic               w_pkt_ok;

    assign w_pkt_phase = {r_hi[3:0], rxfifo_data[6:0]};
    assign w_pkt_ok    = ({1'b0, r_chan} < c_NCH) &&
                         (c_CMP_W'(w_pkt_phase) < c_PERIOD_CMP);

    always_ff @(posedge sys_clk or posedge ext_rst) begin
        if (ext_rst) begin
            r_expect   <= 2'd0;
            r_chan     <= 7'd0;
            r_hi       <= 7'd0;
            r_wr_en    <= 1'b0;
            r_wr_chan  <= 7'd0;
            r_wr_phase <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (r_byte_valid) begin
                if (rxfifo_data[7]) begin
                    r_chan   <= rxfifo_data[6:0];
                    r_expect <= 2'd2;
                end else if (r_expect == 2'd2) begin
                    r_hi     <= rxfifo_data[6:0];
                    r_expect <= 2'd1;
                end else if (r_expect == 2'd1) begin
                    r_expect   <= 2'd0;
                    r_wr_en    <= w_pkt_ok;
                    r_wr_chan  <= r_chan;
                    r_wr_phase <= c_CNT_W'(w_pkt_phase);
                end
            end
        end
    end

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_sync_out;
    logic               w_wrap;

    assign w_wrap = w_sync_edge || (r_cnt == c_CNT_MAX);

    always_ff @(posedge sys_clk or posedge ext_rst) begin
        if (ext_rst) begin
            r_cnt      <= '0;
            r_sync_out <= 1'b0;
        end else begin
            r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
            r_sync_out <= (r_cnt == '0);
        end
    end

    assign sync_out = r_sync_out;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [c_CNT_W-1:0] r_shadow;
        logic [c_CNT_W-1:0] r_phase;
        logic               r_out;
        logic [c_CNT_W:0]   w_diff;

        always_comb begin
            if (r_cnt >= r_phase) begin
                w_diff = {1'b0, r_cnt - r_phase};
            end else begin
                w_diff = {1'b0, r_cnt} + c_PERIOD_X - {1'b0, r_phase};
            end
        end

        always_ff @(posedge sys_clk or posedge ext_rst) begin
            if (ext_rst) begin
                r_shadow <= '0;
                r_phase  <= '0;
                r_out    <= 1'b0;
            end else begin
                if (r_wr_en && (r_wr_chan == 7'(i))) begin
                    r_shadow <= r_wr_phase;
                end
                if (w_wrap) begin
                    r_phase <= r_shadow;
                end
                r_out <= (w_diff < c_HALF);
            end
        end

        assign trans[i] = r_out;
    end

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for top: waveforms are predicted by a cycle-level reference model of
// the carrier timeline and the per-channel phase tables.
module tb_top;

    localparam int NCH  = 128;
    localparam int PER  = 1250;
    localparam int HALF = PER / 2;

    logic            sys_clk = 1'b0;
    logic            ext_rst;
    logic            sync_in;
    logic            sync_out;
    logic [NCH-1:0]  trans;
    logic [7:0]      ft_drv;
    wire  [7:0]      ft_data;
    logic            ft_txen;
    logic            ft_rxfn;
    logic            ft_rdn;
    logic            ft_wrn;
    logic            ft_clk;
    logic            ft_oen;
    logic            ft_siwu;

    assign ft_data = ft_drv;

    int n_checks = 0;
    int n_fail   = 0;

    int             m_ctr;
    int             sync_pend;
    int             m_phase  [NCH];
    int             m_shadow [NCH];
    logic [NCH-1:0] exp_trans;
    logic           exp_sync;

    top #(
        .NUM_CHANNELS (NCH),
        .PERIOD       (PER),
        .RD_LOW       (4),
        .RD_GAP       (3)
    ) dut (
        .sys_clk  (sys_clk),
        .ext_rst  (ext_rst),
        .sync_in  (sync_in),
        .sync_out (sync_out),
        .trans    (trans),
        .ft_data  (ft_data),
        .ft_txen  (ft_txen),
        .ft_rxfn  (ft_rxfn),
        .ft_rdn   (ft_rdn),
        .ft_wrn   (ft_wrn),
        .ft_clk   (ft_clk),
        .ft_oen   (ft_oen),
        .ft_siwu  (ft_siwu)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic model_reset();
        m_ctr     = 0;
        sync_pend = 0;
        for (int i = 0; i < NCH; i++) begin
            m_phase[i]  = 0;
            m_shadow[i] = 0;
        end
    endtask

    // One clock: outputs after the edge show the carrier position held before it.
    task automatic cycle();
        @(posedge sys_clk);
        if (ext_rst) begin
            exp_trans = '0;
            exp_sync  = 1'b0;
        end else begin
            exp_sync = (m_ctr == 0);
            for (int i = 0; i < NCH; i++)
                exp_trans[i] = (((m_ctr - m_phase[i] + PER) % PER) < HALF);
            if (sync_pend == 1) m_ctr = 0;
            else                m_ctr = (m_ctr + 1) % PER;
            if (sync_pend > 0) sync_pend--;
            if (m_ctr == 0) m_phase = m_shadow;
        end
        @(negedge sys_clk);
    endtask

    task automatic wait_window();
        int k;
        k = 0;
        while (!(m_ctr >= 10 && m_ctr < 900) && k < 2 * PER) begin
            cycle();
            k++;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int low);
        int k;
        ft_drv  = b;
        ft_rxfn = 1'b0;
        k = 0;
        while (ft_rdn !== 1'b0 && k < 20) begin
            cycle();
            k++;
        end
        n_checks++;
        if (ft_rdn !== 1'b0) begin
            n_fail++;
            $display("FAIL read_start byte=%h ft_rdn=%b required 0 within 20 cycles", b, ft_rdn);
        end
        ft_rxfn = 1'b1;
        low = 0;
        while (ft_rdn === 1'b0 && low < 20) begin
            low++;
            cycle();
        end
        repeat (6) cycle();
    endtask

    task automatic send_packet(input int ch, input int ph);
        int low;
        wait_window();
        send_byte(8'h80 | 8'(ch), low);
        send_byte(8'(ph >> 7), low);
        send_byte(8'(ph & 32'h7f), low);
        if (ch < NCH && ph < PER) m_shadow[ch] = ph;
    endtask

    task automatic test_reset();
        ext_rst = 1'b1;
        sync_in = 1'b0;
        ft_rxfn = 1'b1;
        ft_txen = 1'b1;
        ft_clk  = 1'b0;
        ft_drv  = 8'h00;
        model_reset();
        repeat (3) cycle();
        n_checks++;
        if (trans !== '0) begin
            n_fail++;
            $display("FAIL reset_trans got=%h required=0", trans);
        end
        n_checks++;
        if (sync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sync_out got=%b required=0", sync_out);
        end
        n_checks++;
        if (ft_rdn !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ft_rdn got=%b required=1", ft_rdn);
        end
        n_checks++;
        if ({ft_wrn, ft_oen, ft_siwu} !== 3'b111) begin
            n_fail++;
            $display("FAIL const_strobes got=%b required=111", {ft_wrn, ft_oen, ft_siwu});
        end
        n_checks++;
        if (dut.rxfifo_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_rxfifo_data got=%h required=00", dut.rxfifo_data);
        end
        ext_rst = 1'b0;
    endtask

    task automatic test_idle();
        int hi0;
        int pulses;
        hi0 = 0;
        pulses = 0;
        for (int c = 0; c < 2600; c++) begin
            cycle();
            if (c < PER && trans[0] === 1'b1) hi0++;
            if (sync_out === 1'b1) pulses++;
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL idle_wave c=%0d trans=%h required=%h sync_out=%b required=%b",
                         c, trans, exp_trans, sync_out, exp_sync);
            end
            n_checks++;
            if (ft_rdn !== 1'b1) begin
                n_fail++;
                $display("FAIL idle_ft_rdn c=%0d got=%b required=1", c, ft_rdn);
            end
        end
        n_checks++;
        if (hi0 != HALF) begin
            n_fail++;
            $display("FAIL idle_high_time got=%0d required=%0d", hi0, HALF);
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL idle_sync_pulses got=%0d required=3", pulses);
        end
    endtask

    task automatic test_read();
        int k;
        int low;
        int high;
        ft_drv  = 8'h55;
        ft_rxfn = 1'b0;
        k = 0;
        while (ft_rdn !== 1'b0 && k < 20) begin
            cycle();
            k++;
        end
        low = 0;
        while (ft_rdn === 1'b0 && low < 20) begin
            low++;
            cycle();
        end
        high = 0;
        while (ft_rdn === 1'b1 && high < 20) begin
            high++;
            cycle();
        end
        ft_rxfn = 1'b1;
        repeat (20) cycle();
        n_checks++;
        if (low != 4) begin
            n_fail++;
            $display("FAIL read_low_time got=%0d required=4", low);
        end
        n_checks++;
        if (high != 3) begin
            n_fail++;
            $display("FAIL read_gap_time got=%0d required=3", high);
        end
        n_checks++;
        if (dut.rxfifo_data !== 8'h55) begin
            n_fail++;
            $display("FAIL read_data got=%h required=55", dut.rxfifo_data);
        end
    endtask

    task automatic test_packet();
        logic p0, p3;
        int   r0, r3;
        bit   seen;
        send_packet(3, 369);
        p0 = trans[0];
        p3 = trans[3];
        r0 = -1;
        r3 = -1;
        seen = 1'b0;
        for (int c = 0; c < 2600; c++) begin
            cycle();
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL packet_wave c=%0d trans=%h required=%h sync_out=%b required=%b",
                         c, trans, exp_trans, sync_out, exp_sync);
            end
            if (sync_out === 1'b1) seen = 1'b1;
            if (seen && r0 < 0 && trans[0] === 1'b1 && p0 === 1'b0) r0 = c;
            if (seen && r3 < 0 && trans[3] === 1'b1 && p3 === 1'b0) r3 = c;
            p0 = trans[0];
            p3 = trans[3];
        end
        n_checks++;
        if (r0 < 0 || r3 < 0 || (r3 - r0) != 369) begin
            n_fail++;
            $display("FAIL packet_delay got=%0d required=369", r3 - r0);
        end
    endtask

    task automatic test_bad_phase();
        send_packet(5, 1280);
        for (int c = 0; c < 1300; c++) begin
            cycle();
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL bad_phase_wave c=%0d trans=%h required=%h", c, trans, exp_trans);
            end
        end
    endtask

    task automatic test_abort();
        int low;
        wait_window();
        send_byte(8'h84, low);
        send_byte(8'h01, low);
        send_packet(6, 16);
        for (int c = 0; c < 1300; c++) begin
            cycle();
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL abort_wave c=%0d trans=%h required=%h", c, trans, exp_trans);
            end
        end
    endtask

    task automatic test_random();
        int low;
        for (int n = 0; n < 6; n++) begin
            wait_window();
            send_byte(8'($urandom_range(0, 127)), low);
            send_packet($urandom_range(0, NCH - 1), $urandom_range(0, 2047));
        end
        for (int c = 0; c < 2600; c++) begin
            cycle();
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL random_wave c=%0d trans=%h required=%h sync_out=%b required=%b",
                         c, trans, exp_trans, sync_out, exp_sync);
            end
        end
    endtask

    task automatic test_sync();
        int k;
        int lat;
        k = 0;
        while (m_ctr != 500 && k < 2 * PER) begin
            cycle();
            k++;
        end
        sync_in   = 1'b1;
        sync_pend = 3;
        lat = -1;
        for (int c = 0; c < 1400; c++) begin
            cycle();
            if (c == 10) sync_in = 1'b0;
            if (sync_out === 1'b1 && lat < 0) lat = c + 1;
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL sync_wave c=%0d trans=%h required=%h sync_out=%b required=%b",
                         c, trans, exp_trans, sync_out, exp_sync);
            end
        end
        n_checks++;
        if (lat < 2 || lat > 6) begin
            n_fail++;
            $display("FAIL sync_latency got=%0d required=2..6", lat);
        end
    endtask

    task automatic test_reset_mid_read();
        int low;
        int k;
        wait_window();
        send_byte(8'h87, low);
        send_byte(8'h01, low);
        ft_drv  = 8'h05;
        ft_rxfn = 1'b0;
        k = 0;
        while (ft_rdn !== 1'b0 && k < 20) begin
            cycle();
            k++;
        end
        ext_rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (ft_rdn !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_ft_rdn got=%b required=1", ft_rdn);
        end
        n_checks++;
        if (trans !== '0 || sync_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midread_outputs trans=%h sync_out=%b required=0/0", trans, sync_out);
        end
        ft_rxfn = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if (dut.rxfifo_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midread_rxfifo_data got=%h required=00", dut.rxfifo_data);
        end
        ext_rst = 1'b0;
        send_byte(8'h05, low);
        for (int c = 0; c < 2600; c++) begin
            cycle();
            n_checks++;
            if (trans !== exp_trans || sync_out !== exp_sync) begin
                n_fail++;
                $display("FAIL post_reset_wave c=%0d trans=%h required=%h sync_out=%b required=%b",
                         c, trans, exp_trans, sync_out, exp_sync);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_read();
        test_packet();
        test_bad_phase();
        test_abort();
        test_random();
        test_sync();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
